// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } btn_state_t;

  // Bits needed to count 0..max(a,b).
  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, tick-sampled debounce with hysteresis,
// edge pulses and the long-press / auto-repeat state machine.
module button_channel
  import button_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn,
  output logic       level,
  output logic       rising_edge,
  output logic       falling_edge,
  output logic       both_edge,
  output logic       long_press,
  output logic       repeat_pulse,
  output btn_state_t state_dbg
);

  localparam int HW = clog2_max(LONG_TICKS, REPEAT_TICKS);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1);
  localparam bit REP_EN = (REPEAT_TICKS != 0);

  logic             sync1, sync2;
  logic [DEPTH-1:0] sh;
  logic             level_q, level_d;
  btn_state_t       state, state_nx;
  logic [HW-1:0]    hold_cnt, hold_nx;
  logic             long_p, rep_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sh       <= '0;
      level_q  <= 1'b0;
      level_d  <= 1'b0;
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (tick) sh <= {sync2, sh[DEPTH-1:1]};
      // Level only moves on a unanimous window; mixed samples hold it.
      if (&sh)       level_q <= 1'b1;
      else if (~|sh) level_q <= 1'b0;
      level_d  <= level_q;
      state    <= state_nx;
      hold_cnt <= hold_nx;
    end
  end

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    long_p   = 1'b0;
    rep_p    = 1'b0;
    if (!level_q) begin
      // Release wins over any pending tick so no pulse accompanies falling_edge.
      state_nx = IDLE;
      hold_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = PRESS;
          hold_nx  = '0;
        end
        PRESS: begin
          if (tick) begin
            if (hold_cnt == LONG_LAST) begin
              long_p   = 1'b1;
              state_nx = HELD;
              hold_nx  = '0;
            end else begin
              hold_nx = hold_cnt + HW'(1);
            end
          end
        end
        HELD: begin
          if (tick && REP_EN) begin
            if (hold_cnt == REP_LAST) begin
              rep_p   = 1'b1;
              hold_nx = '0;
            end else begin
              hold_nx = hold_cnt + HW'(1);
            end
          end
        end
        default: begin
          state_nx = IDLE;
          hold_nx  = '0;
        end
      endcase
    end
  end

  assign level        = level_q;
  assign rising_edge  = level_q & ~level_d;
  assign falling_edge = ~level_q & level_d;
  assign both_edge    = level_q ^ level_d;
  assign long_press   = long_p;
  assign repeat_pulse = rep_p;
  assign state_dbg    = state;

endmodule

// File: rtl/button_debounce_array.sv
// Multi-channel button conditioner: shared sample-tick divider, optional input
// inversion, and NUM_CH independent button_channel instances.
module button_debounce_array
  import button_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CLK_DIV      = 100_000,
  parameter int DEPTH        = 8,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   in_button,
  output logic [NUM_CH-1:0]   level,
  output logic [NUM_CH-1:0]   rising_edge,
  output logic [NUM_CH-1:0]   falling_edge,
  output logic [NUM_CH-1:0]   both_edge,
  output logic [NUM_CH-1:0]   long_press,
  output logic [NUM_CH-1:0]   repeat_pulse,
  output logic [2*NUM_CH-1:0] state_dbg
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0]  div_cnt;
  logic              tick;
  logic [NUM_CH-1:0] btn_pol;
  btn_state_t        ch_state [NUM_CH];

  assign tick    = (div_cnt == CNT_LAST);
  assign btn_pol = ACTIVE_LOW ? ~in_button : in_button;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + CNT_W'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    button_channel #(
      .DEPTH        (DEPTH),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .btn          (btn_pol[i]),
      .level        (level[i]),
      .rising_edge  (rising_edge[i]),
      .falling_edge (falling_edge[i]),
      .both_edge    (both_edge[i]),
      .long_press   (long_press[i]),
      .repeat_pulse (repeat_pulse[i]),
      .state_dbg    (ch_state[i])
    );
    assign state_dbg[2*i +: 2] = ch_state[i];
  end

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed bench for button_debounce_array: two instances (active-high with
// repeat, active-low without repeat) and an event scoreboard keyed by cycle.
module tb_button_debounce_array;
  import button_pkg::*;

  localparam int W = 21;  // {dut, kind[1:0], mask[1:0], cycle[15:0]}

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] in_a, in_b;
  logic [1:0] level_a, rise_a, fall_a, both_a, long_a, rep_a;
  logic [1:0] level_b, rise_b, fall_b, both_b, long_b, rep_b;
  logic [3:0] dbg_a, dbg_b;

  logic [15:0]  cyc;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 16'd1;
  end

  button_debounce_array #(
    .NUM_CH(2), .CLK_DIV(10), .DEPTH(4), .LONG_TICKS(5), .REPEAT_TICKS(3), .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .in_button(in_a), .level(level_a),
    .rising_edge(rise_a), .falling_edge(fall_a), .both_edge(both_a),
    .long_press(long_a), .repeat_pulse(rep_a), .state_dbg(dbg_a)
  );

  button_debounce_array #(
    .NUM_CH(2), .CLK_DIV(10), .DEPTH(4), .LONG_TICKS(5), .REPEAT_TICKS(0), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .in_button(in_b), .level(level_b),
    .rising_edge(rise_b), .falling_edge(fall_b), .both_edge(both_b),
    .long_press(long_b), .repeat_pulse(rep_b), .state_dbg(dbg_b)
  );

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] ev(input bit d, input logic [1:0] k,
                                      input logic [1:0] m, input int c);
    return {d, k, m, 16'(c)};
  endfunction

  task automatic push(input bit d, input logic [1:0] k, input logic [1:0] m, input int c);
    exp_q.push_back(ev(d, k, m, c));
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_evt(input bit d, input logic [1:0] k, input logic [1:0] m);
    logic [W-1:0] got, want;
    if (m != 2'b00) begin
      got = ev(d, k, m, int'(cyc));
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL evt unexpected dut=%0d kind=%0d mask=%b cyc=%0d required none", d, k, m, cyc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL evt got dut=%0d kind=%0d mask=%b cyc=%0d required dut=%0d kind=%0d mask=%b cyc=%0d",
                   d, k, m, cyc, want[20], want[19:18], want[17:16], want[15:0]);
        end
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != 16'(n) && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc got=%0d required=%0d", cyc, n);
    end
  endtask

  // ---------------- monitor: kinds 0 rise, 1 fall, 2 long, 3 repeat ----------------
  always @(negedge clk) begin
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0][15:0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL evt missed required dut=%0d kind=%0d mask=%b cyc=%0d got none",
                 exp_q[0][20], exp_q[0][19:18], exp_q[0][17:16], exp_q[0][15:0]);
        void'(exp_q.pop_front());
      end
      check_evt(1'b0, 2'd0, rise_a);
      check_evt(1'b0, 2'd1, fall_a);
      check_evt(1'b0, 2'd2, long_a);
      check_evt(1'b0, 2'd3, rep_a);
      check_evt(1'b1, 2'd0, rise_b);
      check_evt(1'b1, 2'd1, fall_b);
      check_evt(1'b1, 2'd2, long_b);
      check_evt(1'b1, 2'd3, rep_b);
      if ((rise_a | fall_a | both_a) != 2'b00) check_val("both_a", 32'(both_a), 32'(rise_a | fall_a));
      if ((rise_b | fall_b | both_b) != 2'b00) check_val("both_b", 32'(both_b), 32'(rise_b | fall_b));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    in_a  = 2'b11;
    in_b  = 2'b10;   // active-low: ch0 pressed, ch1 released
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_out_a", 32'({level_a, rise_a, fall_a, both_a, long_a, rep_a}), 32'd0);
    check_val("reset_out_b", 32'({level_b, rise_b, fall_b, both_b, long_b, rep_b}), 32'd0);
    check_val("reset_dbg", 32'({dbg_a, dbg_b}), 32'd0);

    // Run 1 expected events, in cycle order (dut a before dut b within a cycle).
    push(1'b0, 2'd0, 2'b11, 41);
    push(1'b1, 2'd0, 2'b01, 41);
    push(1'b0, 2'd1, 2'b11, 81);
    push(1'b1, 2'd2, 2'b01, 89);
    push(1'b0, 2'd0, 2'b01, 201);
    push(1'b0, 2'd2, 2'b01, 249);
    for (int r = 279; r <= 399; r += 30) push(1'b0, 2'd3, 2'b01, r);
    push(1'b0, 2'd1, 2'b01, 401);
    push(1'b0, 2'd0, 2'b10, 461);
    push(1'b0, 2'd2, 2'b10, 509);
    push(1'b0, 2'd3, 2'b10, 539);
    reset = 1'b0;

    wait_cyc(41);
    check_val("level_a_up", 32'(level_a), 32'h3);
    check_val("level_b_up", 32'(level_b), 32'h1);
    wait_cyc(45);
    in_a = 2'b00;    // short press: released before long_press can fire
    wait_cyc(82);
    check_val("level_a_short_rel", 32'(level_a), 32'h0);

    wait_cyc(100);
    for (int j = 0; j < 60; j++) begin
      in_a = {1'b0, ((j / 3) % 2) == 0};
      @(posedge clk);
      #1;
    end
    in_a = 2'b01;
    wait_cyc(202);
    check_val("level_a_bounce", 32'(level_a), 32'h1);
    wait_cyc(360);
    in_a = 2'b00;
    wait_cyc(420);
    in_a = 2'b10;
    wait_cyc(545);
    check_val("q_empty_run1", 32'(exp_q.size()), 32'd0);
    check_val("dbg_a_ch1_held", 32'(dbg_a[3:2]), 32'(HELD));
    check_val("dbg_b_ch0_held", 32'(dbg_b[1:0]), 32'(HELD));

    // Reset while ch1 of dut_a is in HELD.
    reset = 1'b1;
    #1;
    check_val("midreset_out_a", 32'({level_a, rise_a, fall_a, both_a, long_a, rep_a}), 32'd0);
    check_val("midreset_dbg", 32'({dbg_a, dbg_b}), 32'd0);
    push(1'b0, 2'd0, 2'b10, 41);
    push(1'b1, 2'd0, 2'b01, 41);
    push(1'b0, 2'd1, 2'b10, 81);
    push(1'b1, 2'd2, 2'b01, 89);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    wait_cyc(41);
    check_val("level_a_repress", 32'(level_a), 32'h2);
    wait_cyc(45);
    in_a = 2'b00;
    wait_cyc(150);
    check_val("q_empty_run2", 32'(exp_q.size()), 32'd0);
    check_val("level_a_final", 32'(level_a), 32'h0);
    check_val("level_b_final", 32'(level_b), 32'h1);
    check_val("dbg_b_final", 32'(dbg_b[1:0]), 32'(HELD));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
